piezo_alert_ctrl: RTL and testbench
===================================

Name: piezo_alert_ctrl

Overview:
- Conditions the raw rider, battery and motor-duty status into the three alert flags `norm_mode`, `ovr_spd` and `batt_low`.
- Those flags feed the piezo buzzer driver directly downstream.
- Battery and over-speed paths are filtered with consecutive-sample persistence counters and hysteresis, so the buzzer never chirps on a single noisy A2D reading or PID transient.
- All outputs are registered and glitch-free.

Parameters:
- BATT_LOW_TH, 12'h800: battery reading strictly below this counts as a low sample.
- BATT_HYST, 12'h040: a recovery sample requires `batt >= BATT_LOW_TH + BATT_HYST`; the sum is computed 13-bit, with no wrap.
- OVR_TH, 11'd1536: a `|duty|` strictly above this counts as an over-speed sample.
- OVR_HYST, 11'd128: a recovery sample requires `|duty| <= OVR_TH - OVR_HYST`; the difference is computed 12-bit signed, and a negative result means recovery is impossible.
- BATT_SAMPLES, 8: number of consecutive qualifying battery samples needed to change battery state (range 1..255).
- OVR_SAMPLES, 4: number of consecutive qualifying duty samples needed to change over-speed state (range 1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- pwr_up  in  1  system powered and balancing; low forces all alerts off
- en_steer  in  1  rider present and steering enabled
- batt  in  12  unsigned battery A2D reading
- batt_vld  in  1  one-cycle strobe: `batt` is a new sample
- duty  in  12  signed motor duty from the PID, two's complement
- duty_vld  in  1  one-cycle strobe: `duty` is a new sample
- norm_mode  out  1  normal-riding tone request
- ovr_spd  out  1  over-speed warning
- batt_low  out  1  battery-low warning

Behaviour:

Reset and clocking:
- Reset `rst_n` is synchronous, active-low; clock `clk`.
- On reset, all outputs are 0, both FSMs go to their OK state and both counters go to 0.
- Reset asserted mid-filtering discards partial counts.

Magnitude:
- `|duty|` is an 11-bit unsigned value.
- `duty = -2048` saturates to 2047.
- `duty = 0` gives 0.

Battery FSM (states BATT_OK, BATT_LOW, counter `bcnt`):
- The FSM and `bcnt` update only on cycles with `batt_vld=1`. Cycles with `batt_vld=0` hold state and `bcnt`.
- In BATT_OK: a low sample increments `bcnt`; a non-low sample clears `bcnt`.
- BATT_OK to BATT_LOW: taken when the increment makes `bcnt` equal BATT_SAMPLES; `bcnt` is then cleared.
- In BATT_LOW: a recovery sample increments `bcnt`; any other sample (including one inside the hysteresis band) clears `bcnt`.
- BATT_LOW to BATT_OK: taken when the increment makes `bcnt` equal BATT_SAMPLES; `bcnt` is then cleared.
- `batt_low` is registered and equals (state == BATT_LOW). It changes in the cycle after the qualifying strobe cycle (1-cycle latency).

Over-speed FSM (states OVR_OK, OVR_ACT, counter `ocnt`):
- Identical structure to the battery FSM, driven by `duty_vld` and the `|duty|` thresholds above, using OVR_SAMPLES.
- `ovr_spd` = (state == OVR_ACT), registered, 1-cycle latency.

Independence:
- `batt_vld` and `duty_vld` may be high in the same cycle.
- The two paths are fully independent and both update.

Power-down:
- While `pwr_up=0`, both FSMs are held in OK, both counters are held at 0, and strobes are ignored.
- All outputs are 0 the cycle after `pwr_up` falls.
- Filtering restarts from zero when `pwr_up` rises.

norm_mode:
- Registered: `norm_mode <= pwr_up & en_steer`, giving 1-cycle latency.
- `norm_mode` is not masked by the alerts; the downstream driver prioritises them.

Counters:
- Counters are 8-bit and never exceed BATT_SAMPLES or OVR_SAMPLES, so they cannot wrap.
- With BATT_SAMPLES=1 or OVR_SAMPLES=1, a single sample toggles the state.

Glitch-freedom:
- No output toggles more than once per strobe.
- No output changes on cycles without its strobe, except for `pwr_up` and reset effects.

Test Plan:
- **Battery assert and recover:** `pwr_up=1`; 8 `batt_vld` strobes with `batt=12'h7F0`, spaced 3 cycles apart.
  - `batt_low=1` exactly 1 cycle after the 8th strobe, and 0 before it.
  - Then 8 strobes with `batt=12'h840`: `batt_low=0` 1 cycle after the 8th.
- **Battery break and hysteresis band:** 7 strobes at `12'h700`, then 1 at `12'h900`, then 7 at `12'h700`: `batt_low` stays 0.
  - After reaching BATT_LOW, 8 strobes at `12'h820` (inside the hysteresis band): `batt_low` stays 1.
- **Over-speed magnitude:**
  - 4 `duty_vld` strobes with `duty=-1600`: `ovr_spd=1` 1 cycle after the 4th.
  - Then 4 strobes at `duty=1500` (band): `ovr_spd` stays 1.
  - Then 4 strobes at `duty=1408`: `ovr_spd=0`.
  - 4 strobes at `duty=-2048`: `ovr_spd=1`.
- **Simultaneous strobes:** `batt_vld` and `duty_vld` high together for 8 cycles with `batt=12'h100`, `duty=2000`.
  - `ovr_spd` rises after the 4th strobe.
  - `batt_low` rises after the 8th strobe.
- **Power-down mid-filter:** 6 low-battery strobes, then `pwr_up=0` for 5 cycles, then `pwr_up=1` and 2 more low strobes: `batt_low` stays 0.
  - With `batt_low=1` and `ovr_spd=1`, dropping `pwr_up` gives all outputs 0 next cycle.
- **norm_mode and reset:** `en_steer` toggles with `pwr_up=1`: `norm_mode` follows with 1-cycle delay.
  - Asserting `rst_n=0` for 1 cycle after 3 low-battery strobes: all outputs 0, and 8 new strobes are required before `batt_low` asserts.

Source files
------------

// File: rtl/piezo_alert_if.sv
// Status/alert bundle between the rider/battery/PID side and the alert conditioner.
interface piezo_alert_if;
  logic        pwr_up;
  logic        en_steer;
  logic [11:0] batt;
  logic        batt_vld;
  logic [11:0] duty;
  logic        duty_vld;
  logic        norm_mode;
  logic        ovr_spd;
  logic        batt_low;

  // Source of raw status, consumer of alert flags.
  modport master (
    output pwr_up, en_steer, batt, batt_vld, duty, duty_vld,
    input  norm_mode, ovr_spd, batt_low
  );

  // Alert conditioner.
  modport slave (
    input  pwr_up, en_steer, batt, batt_vld, duty, duty_vld,
    output norm_mode, ovr_spd, batt_low
  );
endinterface

// File: rtl/piezo_alert_ctrl.sv
// Piezo alert conditioner: turns raw battery / motor-duty samples into
// debounced, hysteretic alert flags for the buzzer driver. Each alert path
// is a two-state FSM with a consecutive-sample persistence counter.
module piezo_alert_ctrl #(
  parameter logic [11:0] BATT_LOW_TH  = 12'h800,
  parameter logic [11:0] BATT_HYST    = 12'h040,
  parameter logic [10:0] OVR_TH       = 11'd1536,
  parameter logic [10:0] OVR_HYST     = 11'd128,
  parameter int          BATT_SAMPLES = 8,
  parameter int          OVR_SAMPLES  = 4
) (
  input logic          clk,
  input logic          rst_n,
  piezo_alert_if.slave bus
);

  typedef enum logic {BATT_OK = 1'b0, BATT_LOW = 1'b1} batt_state_t;
  typedef enum logic {OVR_OK  = 1'b0, OVR_ACT  = 1'b1} ovr_state_t;

  // Recovery thresholds, widened so the hysteresis arithmetic cannot wrap.
  localparam logic [12:0]        BATT_REC_TH = {1'b0, BATT_LOW_TH} + {1'b0, BATT_HYST};
  localparam logic signed [11:0] OVR_REC_TH  = $signed({1'b0, OVR_TH}) - $signed({1'b0, OVR_HYST});
  localparam logic [7:0]         BATT_N      = 8'(BATT_SAMPLES);
  localparam logic [7:0]         OVR_N       = 8'(OVR_SAMPLES);

  batt_state_t bstate, bstate_n;
  ovr_state_t  ostate, ostate_n;
  logic [7:0]  bcnt, bcnt_n, bcnt_inc;
  logic [7:0]  ocnt, ocnt_n, ocnt_inc;

  logic [11:0] duty_neg;
  logic [10:0] duty_mag;
  logic        batt_is_low, batt_is_rec, bqual;
  logic        ovr_is_high, ovr_is_rec, oqual;

  logic norm_mode_q, ovr_spd_q, batt_low_q;

  // |duty| as 11-bit unsigned; the single unrepresentable value saturates.
  assign duty_neg = ~bus.duty + 12'd1;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    duty_mag = bus.duty[10:0];
    if (bus.duty == 12'h800)
      duty_mag = 11'h7FF;
    else if (bus.duty[11])
      duty_mag = duty_neg[10:0];
  end

  // Sample classification; a negative over-speed recovery threshold disables recovery.
  assign batt_is_low = bus.batt < BATT_LOW_TH;
  assign batt_is_rec = {1'b0, bus.batt} >= BATT_REC_TH;
  assign ovr_is_high = duty_mag > OVR_TH;
  assign ovr_is_rec  = !OVR_REC_TH[11] && ($signed({1'b0, duty_mag}) <= OVR_REC_TH);

  // A sample "qualifies" when it argues for leaving the current state.
  assign bqual    = (bstate == BATT_OK) ? batt_is_low : batt_is_rec;
  assign oqual    = (ostate == OVR_OK)  ? ovr_is_high : ovr_is_rec;
  assign bcnt_inc = bcnt + 8'd1;
  assign ocnt_inc = ocnt + 8'd1;

  // Battery FSM next state: power-down parks it, otherwise only strobes advance it.
  always_comb begin
    bstate_n = bstate;
    bcnt_n   = bcnt;
    if (!bus.pwr_up) begin
      bstate_n = BATT_OK;
      bcnt_n   = '0;
    end else if (bus.batt_vld) begin
      if (!bqual) begin
        bcnt_n = '0;
      end else if (bcnt_inc == BATT_N) begin
        bcnt_n = '0;
        case (bstate)
          BATT_OK:  bstate_n = BATT_LOW;
          default:  bstate_n = BATT_OK;
        endcase
      end else begin
        bcnt_n = bcnt_inc;
      end
    end
  end

  // Over-speed FSM next state: same persistence scheme, driven by duty samples.
  always_comb begin
    ostate_n = ostate;
    ocnt_n   = ocnt;
    if (!bus.pwr_up) begin
      ostate_n = OVR_OK;
      ocnt_n   = '0;
    end else if (bus.duty_vld) begin
      if (!oqual) begin
        ocnt_n = '0;
      end else if (ocnt_inc == OVR_N) begin
        ocnt_n = '0;
        case (ostate)
          OVR_OK:   ostate_n = OVR_ACT;
          default:  ostate_n = OVR_OK;
        endcase
      end else begin
        ocnt_n = ocnt_inc;
      end
    end
  end

  // State, counters and alert flags; flags are flops fed from next state so
  // they track the FSMs with one cycle of latency and never glitch.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      bstate      <= BATT_OK;
      ostate      <= OVR_OK;
      bcnt        <= '0;
      ocnt        <= '0;
      norm_mode_q <= 1'b0;
      ovr_spd_q   <= 1'b0;
      batt_low_q  <= 1'b0;
    end else begin
      bstate      <= bstate_n;
      ostate      <= ostate_n;
      bcnt        <= bcnt_n;
      ocnt        <= ocnt_n;
      norm_mode_q <= bus.pwr_up & bus.en_steer;
      ovr_spd_q   <= (ostate_n == OVR_ACT);
      batt_low_q  <= (bstate_n == BATT_LOW);
    end
  end

  assign bus.norm_mode = norm_mode_q;
  assign bus.ovr_spd   = ovr_spd_q;
  assign bus.batt_low  = batt_low_q;

endmodule

// File: tb/tb_piezo_alert_ctrl.sv
// Scoreboard bench for piezo_alert_ctrl: the driver pushes the expected
// outputs from a run-length reference model; a monitor pops and compares.
module tb_piezo_alert_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  piezo_alert_if ifc ();
  piezo_alert_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int n_tests = 0;
  int n_fail  = 0;

  // Expected {norm_mode, ovr_spd, batt_low} after the next rising edge.
  logic [2:0] exp_q[$];

  // Current level-type inputs.
  bit cur_rst = 1'b0, cur_pu = 1'b0, cur_es = 1'b0;

  // Reference model: alert flags plus run length of consecutive qualifying samples.
  bit m_nm = 0, m_os = 0, m_bl = 0;
  int b_run = 0, o_run = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit bv, input int b, input bit dv, input int d);
    int  mag;
    bit  qual;
    if (!cur_rst || !cur_pu) begin
      m_nm = 0; m_os = 0; m_bl = 0; b_run = 0; o_run = 0;
      return;
    end
    m_nm = cur_es;
    if (bv) begin
      qual  = m_bl ? (b >= 2048 + 64) : (b < 2048);
      b_run = qual ? b_run + 1 : 0;
      if (b_run == 8) begin m_bl = !m_bl; b_run = 0; end
    end
    if (dv) begin
      mag   = (d < 0) ? -d : d;
      if (mag > 2047) mag = 2047;
      qual  = m_os ? (mag <= 1536 - 128) : (mag > 1536);
      o_run = qual ? o_run + 1 : 0;
      if (o_run == 4) begin m_os = !m_os; o_run = 0; end
    end
  endtask

  // Drive one cycle of inputs at the falling edge and record the expectation.
  task automatic step(input bit bv, input int b, input bit dv, input int d);
    @(negedge clk);
    rst_n        = cur_rst;
    ifc.pwr_up   = cur_pu;
    ifc.en_steer = cur_es;
    ifc.batt     = b[11:0];
    ifc.batt_vld = bv;
    ifc.duty     = d[11:0];
    ifc.duty_vld = dv;
    model_step(bv, b, dv, d);
    exp_q.push_back({m_nm, m_os, m_bl});
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  task automatic bstrobes(input int b, input int n, input int gap);
    repeat (n) begin
      step(1, b, 0, 0);
      idle(gap);
    end
  endtask

  task automatic dstrobes(input int d, input int n);
    repeat (n) step(0, 0, 1, d);
  endtask

  // Wait until the outputs reflect the last driven cycle.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic power_cycle();
    cur_pu = 0; idle(2);
    cur_pu = 1; idle(1);
  endtask

  // Monitor: compare DUT outputs just after each edge against the scoreboard.
  initial begin
    logic [2:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", int'({ifc.norm_mode, ifc.ovr_spd, ifc.batt_low}), int'(e));
      end
    end
  end

  initial begin
    int bmode, dmode, b, d;
    rst_n = 1'b0;
    ifc.pwr_up = 0; ifc.en_steer = 0; ifc.batt = '0; ifc.batt_vld = 0;
    ifc.duty = '0; ifc.duty_vld = 0;

    idle(2);
    settle();
    check("reset_state", int'({ifc.norm_mode, ifc.ovr_spd, ifc.batt_low}), 0);
    cur_rst = 1; cur_pu = 1; cur_es = 1;
    idle(1);

    // Battery assert and recover, strobes 3 cycles apart.
    bstrobes(12'h7F0, 7, 2);
    settle(); check("batt_pre_assert", ifc.batt_low, 0);
    step(1, 12'h7F0, 0, 0);
    settle(); check("batt_assert", ifc.batt_low, 1);
    idle(2);
    bstrobes(12'h840, 7, 2);
    settle(); check("batt_pre_recover", ifc.batt_low, 1);
    step(1, 12'h840, 0, 0);
    settle(); check("batt_recover", ifc.batt_low, 0);

    // Broken run and hysteresis band.
    bstrobes(12'h700, 7, 0);
    bstrobes(12'h900, 1, 0);
    bstrobes(12'h700, 7, 0);
    settle(); check("batt_break", ifc.batt_low, 0);
    bstrobes(12'h700, 1, 0);
    settle(); check("batt_after_break", ifc.batt_low, 1);
    bstrobes(12'h820, 8, 1);
    settle(); check("batt_band_hold", ifc.batt_low, 1);
    power_cycle();

    // Over-speed magnitude, band, recovery and saturation.
    dstrobes(-1600, 3);
    settle(); check("ovr_pre_assert", ifc.ovr_spd, 0);
    dstrobes(-1600, 1);
    settle(); check("ovr_assert_neg", ifc.ovr_spd, 1);
    dstrobes(1500, 4);
    settle(); check("ovr_band_hold", ifc.ovr_spd, 1);
    dstrobes(1408, 4);
    settle(); check("ovr_recover", ifc.ovr_spd, 0);
    dstrobes(-2048, 4);
    settle(); check("ovr_saturate", ifc.ovr_spd, 1);
    power_cycle();

    // Simultaneous strobes on both paths.
    repeat (4) step(1, 12'h100, 1, 2000);
    settle(); check("simul_ovr", ifc.ovr_spd, 1);
    check("simul_batt_early", ifc.batt_low, 0);
    repeat (4) step(1, 12'h100, 1, 2000);
    settle(); check("simul_batt", ifc.batt_low, 1);
    cur_pu = 0; idle(1);
    settle(); check("pwr_down_clear", int'({ifc.norm_mode, ifc.ovr_spd, ifc.batt_low}), 0);

    // Power-down mid-filter discards partial counts.
    cur_pu = 1; idle(1);
    bstrobes(12'h100, 6, 0);
    cur_pu = 0; idle(5);
    cur_pu = 1;
    bstrobes(12'h100, 2, 0);
    settle(); check("pwr_restart", ifc.batt_low, 0);

    // norm_mode follows pwr_up & en_steer.
    cur_es = 0; idle(1);
    settle(); check("norm_off", ifc.norm_mode, 0);
    cur_es = 1; idle(1);
    settle(); check("norm_on", ifc.norm_mode, 1);

    // Reset mid-filter.
    bstrobes(12'h100, 3, 0);
    cur_rst = 0; idle(1);
    settle(); check("reset_mid", int'({ifc.norm_mode, ifc.ovr_spd, ifc.batt_low}), 0);
    cur_rst = 1;
    bstrobes(12'h100, 7, 0);
    settle(); check("reset_restart_pre", ifc.batt_low, 0);
    bstrobes(12'h100, 1, 0);
    settle(); check("reset_restart", ifc.batt_low, 1);

    // Randomized traffic with sticky value regions so alerts actually toggle.
    bmode = 0; dmode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        bmode = int'($urandom_range(0, 3));
        dmode = int'($urandom_range(0, 3));
      end
      cur_rst = ($urandom_range(0, 599) != 0);
      cur_pu  = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 19) == 0) cur_es = !cur_es;
      case (bmode)
        0: b = int'($urandom_range(0, 12'h7FF));
        1: b = int'($urandom_range(12'h800, 12'h83F));
        2: b = int'($urandom_range(12'h840, 12'hFFF));
        default: b = int'($urandom_range(0, 12'hFFF));
      endcase
      case (dmode)
        0: d = int'($urandom_range(1537, 2048));
        1: d = int'($urandom_range(1409, 1536));
        2: d = int'($urandom_range(0, 1408));
        default: d = int'($urandom_range(0, 2048));
      endcase
      if ($urandom_range(0, 1) == 1) d = -d;
      if (d > 2047) d = 2047;
      step(($urandom_range(0, 2) == 0), b, ($urandom_range(0, 1) == 0), d);
    end

    idle(2);
    settle();
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
